// File: rtl/iir_sos_cascade.sv
// Cascade of NUM_STAGES direct-form-I biquads sharing one multiplier, with host-loaded coefficients.
// Define SOS_SATURATE_EN to clamp rounded results; otherwise they wrap to DATA_SIZE bits.
module iir_sos_cascade #(
    parameter int COEF_SIZE  = 20,
    parameter int COEF_FRAC  = 18,
    parameter int DATA_SIZE  = 24,
    parameter int NUM_STAGES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_SIZE-1:0]              data_in,
    input  logic                              sample_trig,
    output logic [DATA_SIZE-1:0]              data_out,
    output logic                              filter_done,
    output logic                              busy,
    output logic                              overrun,
    input  logic                              coef_we,
    input  logic [$clog2(NUM_STAGES)+2:0]     coef_addr,
    input  logic [COEF_SIZE-1:0]              coef_data
);

    localparam int PROD_W = COEF_SIZE + DATA_SIZE;
    localparam int ACC_W  = PROD_W + 3;
    localparam int ADDR_W = $clog2(NUM_STAGES) + 3;
    localparam int STG_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MAC    = 3'd1;
    localparam logic [2:0] S_SCALE  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
    localparam logic signed [COEF_SIZE-1:0] COEF_ONE =
        {{(COEF_SIZE-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};
    localparam logic signed [ACC_W:0] RND_C =
        {{(ACC_W-COEF_FRAC+1){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-DATA_SIZE+2){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W-DATA_SIZE+2){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    // Round half up at the binary point, then clamp or wrap to the sample width.
    function automatic logic signed [DATA_SIZE-1:0] round_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] sh;
        t  = {a[ACC_W-1], a} + RND_C;
        sh = t >>> COEF_FRAC;
`ifdef SOS_SATURATE_EN
        if (sh > SAT_MAX) begin
            return SAT_MAX[DATA_SIZE-1:0];
        end else if (sh < SAT_MIN) begin
            return SAT_MIN[DATA_SIZE-1:0];
        end else begin
            return sh[DATA_SIZE-1:0];
        end
`else
        return sh[DATA_SIZE-1:0];
`endif
    endfunction

    logic signed [COEF_SIZE-1:0] coef_q [NUM_STAGES][6];
    logic signed [DATA_SIZE-1:0] x1_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] x2_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] v1_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] v2_q [NUM_STAGES];

    logic [2:0]                  state_q, state_d;
    logic [STG_W-1:0]            stage_q, stage_d;
    logic [2:0]                  tap_q, tap_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [DATA_SIZE-1:0] x_q, x_d, v_q, v_d, y_q, y_d, dout_q, dout_d;
    logic                        done_q, done_d, busy_q, busy_d, ovr_q, ovr_d;

    logic signed [COEF_SIZE-1:0] mul_a_s;
    logic signed [DATA_SIZE-1:0] mul_b_s;
    logic signed [PROD_W-1:0]    prod_s;
    logic signed [ACC_W-1:0]     prod_ext_s;
    logic signed [DATA_SIZE-1:0] v_s, y_s;
    logic [ADDR_W-1:0]           wr_stage_s;
    logic                        wr_ok_s;

    // Multiplier operand select: the five taps during MAC, then GAIN times v during SCALE.
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        case (state_q)
            S_MAC: begin
                case (tap_q)
                    3'd0:    begin mul_a_s = coef_q[stage_q][0]; mul_b_s = x_q;             end
                    3'd1:    begin mul_a_s = coef_q[stage_q][1]; mul_b_s = x1_q[stage_q];   end
                    3'd2:    begin mul_a_s = coef_q[stage_q][2]; mul_b_s = x2_q[stage_q];   end
                    3'd3:    begin mul_a_s = coef_q[stage_q][3]; mul_b_s = v1_q[stage_q];   end
                    3'd4:    begin mul_a_s = coef_q[stage_q][4]; mul_b_s = v2_q[stage_q];   end
                    default: begin mul_a_s = '0;                 mul_b_s = '0;              end
                endcase
            end
            S_SCALE: begin
                mul_a_s = coef_q[stage_q][5];
                mul_b_s = v_s;
            end
            default: begin
                mul_a_s = '0;
                mul_b_s = '0;
            end
        endcase
    end

    assign prod_s     = mul_a_s * mul_b_s;
    assign prod_ext_s = {{3{prod_s[PROD_W-1]}}, prod_s};
    assign v_s        = round_fn(acc_q);
    assign y_s        = round_fn(prod_ext_s);

    assign wr_stage_s = coef_addr >> 3;
    assign wr_ok_s    = coef_we && (state_q == S_IDLE) && (coef_addr[2:0] < 3'd6) &&
                        ({{(32-ADDR_W){1'b0}}, wr_stage_s} < NUM_STAGES);

    // Sequencer and datapath next-state.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        x_d     = x_q;
        v_d     = v_q;
        y_d     = y_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (sample_trig & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (sample_trig) begin
                    state_d = S_MAC;
                    stage_d = '0;
                    tap_d   = 3'd0;
                    x_d     = data_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                if (tap_q == 3'd0) begin
                    acc_d = prod_ext_s;
                end else if (tap_q < 3'd3) begin
                    acc_d = acc_q + prod_ext_s;
                end else begin
                    acc_d = acc_q - prod_ext_s;
                end
                if (tap_q == 3'd4) begin
                    state_d = S_SCALE;
                    tap_d   = 3'd0;
                end else begin
                    tap_d   = tap_q + 3'd1;
                end
            end
            S_SCALE: begin
                v_d     = v_s;
                y_d     = y_s;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                x_d = y_q;
                if (stage_q == LAST_STAGE) begin
                    state_d = S_DONE;
                    dout_d  = y_q;
                    done_d  = 1'b1;
                end else begin
                    stage_d = stage_q + STG_W'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            tap_q   <= 3'd0;
            acc_q   <= '0;
            x_q     <= '0;
            v_q     <= '0;
            y_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            v_q     <= v_d;
            y_q     <= y_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Coefficient file and per-stage history; reset restores pass-through sections.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                coef_q[s][0] <= COEF_ONE;
                coef_q[s][1] <= '0;
                coef_q[s][2] <= '0;
                coef_q[s][3] <= '0;
                coef_q[s][4] <= '0;
                coef_q[s][5] <= COEF_ONE;
                x1_q[s]      <= '0;
                x2_q[s]      <= '0;
                v1_q[s]      <= '0;
                v2_q[s]      <= '0;
            end
        end else begin
            if (wr_ok_s) begin
                coef_q[wr_stage_s[STG_W-1:0]][coef_addr[2:0]] <= coef_data;
            end
            if (state_q == S_UPDATE) begin
                x2_q[stage_q] <= x1_q[stage_q];
                x1_q[stage_q] <= x_q;
                v2_q[stage_q] <= v1_q[stage_q];
                v1_q[stage_q] <= v_q;
            end
        end
    end

    assign data_out    = dout_q;
    assign filter_done = done_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Scoreboard bench for iir_sos_cascade against an integer biquad-cascade reference model.
module tb_iir_sos_cascade;

    localparam int NS  = 4;
    localparam int CF  = 18;
    localparam int LAT = 7 * NS + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] data_in;
    logic        sample_trig;
    logic [23:0] data_out;
    logic        filter_done;
    logic        busy;
    logic        overrun;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [19:0] coef_data;

    always #5 clk = ~clk;

    iir_sos_cascade #(
        .COEF_SIZE (20),
        .COEF_FRAC (CF),
        .DATA_SIZE (24),
        .NUM_STAGES(NS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .sample_trig(sample_trig),
        .data_out   (data_out),
        .filter_done(filter_done),
        .busy       (busy),
        .overrun    (overrun),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data)
    );

    longint m_coef [NS][6];
    longint m_x1 [NS];
    longint m_x2 [NS];
    longint m_v1 [NS];
    longint m_v2 [NS];
    longint exp_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint fit(input longint a);
`ifdef SOS_SATURATE_EN
        if (a > 64'sd8388607) return 64'sd8388607;
        else if (a < -64'sd8388608) return -64'sd8388608;
        else return a;
`else
        longint w;
        w = a & 64'sh0000_0000_00FF_FFFF;
        if (w > 64'sd8388607) w = w - 64'sd16777216;
        return w;
`endif
    endfunction

    function automatic longint rnd(input longint a);
        return fit((a + (64'sd1 <<< (CF - 1))) >>> CF);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_coef[s][0] = 64'sd1 <<< CF;
            m_coef[s][1] = 0;
            m_coef[s][2] = 0;
            m_coef[s][3] = 0;
            m_coef[s][4] = 0;
            m_coef[s][5] = 64'sd1 <<< CF;
            m_x1[s] = 0; m_x2[s] = 0; m_v1[s] = 0; m_v2[s] = 0;
        end
    endfunction

    function automatic longint model_run(input longint x_in);
        longint x, v, y;
        x = x_in;
        for (int s = 0; s < NS; s++) begin
            v = rnd(m_coef[s][0] * x + m_coef[s][1] * m_x1[s] + m_coef[s][2] * m_x2[s]
                    - m_coef[s][3] * m_v1[s] - m_coef[s][4] * m_v2[s]);
            y = rnd(m_coef[s][5] * v);
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_v2[s] = m_v1[s]; m_v1[s] = v;
            x = y;
        end
        return x;
    endfunction

    // Monitor: every filter_done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        longint e;
        if (filter_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_filter_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", longint'($signed(data_out)), e);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("busy_timeout", 1, 0);
    endtask

    task automatic coef_write(input int s, input int k, input longint val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 5'(s * 8 + k);
        coef_data = 20'(val);
        @(negedge clk);
        coef_we   = 1'b0;
        if (k < 6 && s < NS) m_coef[s][k] = val;
    endtask

    task automatic send(input longint d);
        int n;
        wait_idle();
        data_in     = 24'(d);
        sample_trig = 1'b1;
        exp_q.push_back(model_run(d));
        @(negedge clk);
        sample_trig = 1'b0;
        n = 1;
        while (!filter_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; data_in = '0; sample_trig = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset_data_out", longint'(data_out), 0);
        check("reset_filter_done", longint'(filter_done), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_overrun", longint'(overrun), 0);

        // Pass-through defaults, including the most negative sample.
        send(1000);
        send(-8388608);

        // FIR taps: 0.5*x, then 0.5*x + 0.5*x1.
        coef_write(0, 0, 131072);
        send(1000); send(0); send(0);
        coef_write(0, 1, 131072);
        send(1000); send(0); send(0);

        // Recursion: v = x + 0.5*v1.
        do_reset();
        coef_write(0, 3, -131072);
        send(1024); send(0); send(0); send(0);

        // Gain just under 2.0 pushes past full scale.
        do_reset();
        coef_write(0, 5, 524287);
        send(5000000);
        send(-5000000);

        // Reserved indices must not disturb anything.
        do_reset();
        coef_write(0, 6, 12345);
        coef_write(1, 7, -200000);
        send(1000);

        // Randomized coefficients and samples.
        do_reset();
        for (int s = 0; s < NS; s++) begin
            coef_write(s, 0, longint'($urandom_range(0, 262144)) - 131072);
            coef_write(s, 1, longint'($urandom_range(0, 131072)) - 65536);
            coef_write(s, 2, longint'($urandom_range(0, 131072)) - 65536);
            coef_write(s, 3, longint'($urandom_range(0, 131072)) - 65536);
            coef_write(s, 4, longint'($urandom_range(0, 65536)) - 32768);
            coef_write(s, 5, longint'($urandom_range(0, 262144)) + 131072);
        end
        for (int i = 0; i < 24; i++) begin
            send(longint'($urandom_range(0, 16777215)) - 8388608);
        end

        // Trigger and coefficient write while busy: flagged/dropped, result unaffected.
        do_reset();
        wait_idle();
        data_in = 24'd4321;
        sample_trig = 1'b1;
        exp_q.push_back(model_run(4321));
        @(negedge clk);
        sample_trig = 1'b0;
        repeat (8) @(negedge clk);
        data_in = 24'd99;
        sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        check("overrun_set", longint'(overrun), 1);
        check("busy_during_run", longint'(busy), 1);
        coef_we = 1'b1; coef_addr = 5'd0; coef_data = 20'd131072;
        @(negedge clk);
        coef_we = 1'b0;
        wait_idle();
        check("overrun_sticky", longint'(overrun), 1);
        send(1000);

        // Reset mid-computation, colliding with a trigger and a coefficient write.
        coef_write(1, 0, 131072);
        wait_idle();
        data_in = 24'd2000;
        sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        repeat (13) @(negedge clk);
        reset = 1'b1; sample_trig = 1'b1; coef_we = 1'b1; coef_addr = 5'd0; coef_data = 20'd0;
        @(negedge clk);
        reset = 1'b0; sample_trig = 1'b0; coef_we = 1'b0;
        model_reset();
        check("abort_data_out", longint'(data_out), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_overrun", longint'(overrun), 0);
        check("abort_filter_done", longint'(filter_done), 0);
        repeat (40) @(negedge clk);
        send(777);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
